// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode encodings, iterator modes and FSM states for alu_seq.
// Optional divide (state DIV, opcode 011) is compiled in with ALU_SEQ_DIV_EN.
`default_nettype none

package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
`ifdef ALU_SEQ_DIV_EN
        ,
        S_DIV  = 2'd2
`endif
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: shared iterative datapath (shift-add multiply, restoring divide).
// The divide half exists only when ALU_SEQ_DIV_EN is defined.
`default_nettype none

module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    // The start edge performs iteration 0, so the final iteration happens
    // on the edge that moves the counter from WIDTH-2 to WIDTH-1.
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);

    logic             running;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;   // product accumulator / partial remainder
    logic [WIDTH-1:0] opa;   // multiplicand / dividend-quotient shifter
    logic [WIDTH-1:0] opb;   // multiplier / divisor
    logic             go;
    logic [WIDTH-1:0] cur_acc, cur_a, cur_b;
    logic [WIDTH-1:0] nxt_acc, nxt_a, nxt_b;

    always_comb begin
        cur_acc = go ? '0 : acc;
        cur_a   = go ? a  : opa;
        cur_b   = go ? b  : opb;
    end

`ifdef ALU_SEQ_DIV_EN
    logic           div_mode;
    logic           cur_div;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    assign go = start;

    always_comb begin
        cur_div = go ? mode : div_mode;
        rem_sh  = {cur_acc, cur_a[WIDTH-1]};
        diff    = rem_sh - {1'b0, cur_b};
        nxt_acc = cur_acc + (cur_b[0] ? cur_a : '0);
        nxt_a   = cur_a << 1;
        nxt_b   = cur_b >> 1;
        if (cur_div) begin
            nxt_b = cur_b;
            if (!diff[WIDTH]) begin
                nxt_acc = diff[WIDTH-1:0];
                nxt_a   = {cur_a[WIDTH-2:0], 1'b1};
            end else begin
                nxt_acc = rem_sh[WIDTH-1:0];
                nxt_a   = {cur_a[WIDTH-2:0], 1'b0};
            end
        end
        result = cur_div ? nxt_a : nxt_acc;
    end
`else
    // Without a divider, a divide-mode start has nothing to run.
    assign go = start && (mode != MODE_DIV);

    always_comb begin
        nxt_acc = cur_acc + (cur_b[0] ? cur_a : '0);
        nxt_a   = cur_a << 1;
        nxt_b   = cur_b >> 1;
        result  = nxt_acc;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            opa     <= '0;
            opb     <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_mode <= 1'b0;
`endif
        end else if (go || running) begin
            acc     <= nxt_acc;
            opa     <= nxt_a;
            opb     <= nxt_b;
            cnt     <= go ? '0 : cnt + CW'(1);
            running <= go ? 1'b1 : (cnt != LAST);
`ifdef ALU_SEQ_DIV_EN
            div_mode <= cur_div;
`endif
        end
    end

    assign done = running && (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshake and registered result/Zero.
// Define ALU_SEQ_DIV_EN to enable the iterative unsigned divide on opcode 011.
`default_nettype none

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       ALUCtrl_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o,
    output logic             valid_o
);

    state_t           state, state_nx;
    logic             accept;
    logic             is_iter;
    logic             iter_mode;
    logic             iter_start;
    logic             iter_done;
    logic             write;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] iter_res;
    logic [WIDTH-1:0] wr_data;

    assign ready_o = (state == S_IDLE);
    assign accept  = valid_i && ready_o;

    always_comb begin
        single_res = data1_i;
        case (ALUCtrl_i)
            OP_AND:  single_res = data1_i & data2_i;
            OP_OR:   single_res = data1_i | data2_i;
            OP_ADD:  single_res = data1_i + data2_i;
            OP_SUB:  single_res = data1_i - data2_i;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
`ifndef ALU_SEQ_DIV_EN
            OP_DIV:  single_res = data1_i;
`endif
            default: single_res = data1_i;
        endcase
    end

    always_comb begin
        is_iter   = (ALUCtrl_i == OP_MUL);
        iter_mode = MODE_MUL;
`ifdef ALU_SEQ_DIV_EN
        if (ALUCtrl_i == OP_DIV) begin
            is_iter   = 1'b1;
            iter_mode = MODE_DIV;
        end
`endif
    end

    always_comb begin
        state_nx   = state;
        iter_start = 1'b0;
        write      = 1'b0;
        wr_data    = single_res;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_iter) begin
                        iter_start = 1'b1;
`ifdef ALU_SEQ_DIV_EN
                        state_nx   = (iter_mode == MODE_DIV) ? S_DIV : S_MUL;
`else
                        state_nx   = S_MUL;
`endif
                    end else begin
                        write = 1'b1;
                    end
                end
            end
`ifdef ALU_SEQ_DIV_EN
            S_MUL, S_DIV: begin
`else
            S_MUL: begin
`endif
                if (iter_done) begin
                    write    = 1'b1;
                    wr_data  = iter_res;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    alu_seq_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .start  (iter_start),
        .mode   (iter_mode),
        .a      (data1_i),
        .b      (data2_i),
        .done   (iter_done),
        .result (iter_res)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            data_o  <= '0;
            Zero_o  <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            state   <= state_nx;
            valid_o <= write;
            if (write) begin
                data_o <= wr_data;
                Zero_o <= (wr_data == '0);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// tb_alu_seq: drives a WIDTH=32 and a WIDTH=8 alu_seq in lockstep against a
// reference model; divide expectations follow ALU_SEQ_DIV_EN.
`default_nettype none

module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e32;
        logic [7:0]  e8;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] data1, data2;
    logic [2:0]  op;
    logic        ready32, zero32, vout32;
    logic [31:0] data32;
    logic        ready8, zero8, vout8;
    logic [7:0]  data8;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vt[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready32),
        .data1_i(data1), .data2_i(data2), .ALUCtrl_i(op),
        .data_o(data32), .Zero_o(zero32), .valid_o(vout32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready8),
        .data1_i(data1[7:0]), .data2_i(data2[7:0]), .ALUCtrl_i(op),
        .data_o(data8), .Zero_o(zero8), .valid_o(vout8)
    );

    task automatic chk(input string nm, input string what, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, what, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a_in,
                                          input logic [31:0] b_in, input int w);
        longint unsigned m, a, b, r;
        longint sa, sb;
        m  = (64'd1 << w) - 64'd1;
        a  = {32'd0, a_in} & m;
        b  = {32'd0, b_in} & m;
        sa = ((a >> (w - 1)) != 0) ? longint'(a) - longint'(m) - 1 : longint'(a);
        sb = ((b >> (w - 1)) != 0) ? longint'(b) - longint'(m) - 1 : longint'(b);
        case (o)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = (a + b) & m;
            3'b110:  r = (a - b) & m;
            3'b100:  r = (a * b) & m;
            3'b111:  r = (sa < sb) ? 64'd1 : 64'd0;
`ifdef ALU_SEQ_DIV_EN
            3'b011:  r = (b == 0) ? m : a / b;
`endif
            default: r = a;
        endcase
        return r[31:0];
    endfunction

    function automatic int lat(input logic [2:0] o, input int w);
`ifdef ALU_SEQ_DIV_EN
        if (o == 3'b011) return w;
`endif
        return (o == 3'b100) ? w : 1;
    endfunction

    // Issue one op to both DUTs, scramble inputs after accept, then wait for each result.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e32, input logic [7:0] e8, input string nm);
        int n;
        bit got32, got8;
        int busy32, busy8;
        op = o; data1 = a; data2 = b; valid_i = 1'b1;
        tick();
        valid_i = 1'b0; op = 3'($urandom); data1 = $urandom; data2 = $urandom;
        n = 1; got32 = 0; got8 = 0; busy32 = 0; busy8 = 0;
        while ((!got32 || !got8) && n <= 64) begin
            if (!got32) begin
                if (vout32) begin
                    got32 = 1;
                    chk(nm, "lat32", 32'(n), 32'(lat(o, 32)));
                    chk(nm, "data32", data32, e32);
                    chk(nm, "zero32", 32'(zero32), 32'(e32 == 32'd0));
                    chk(nm, "ready32_at_valid", 32'(ready32), 32'd1);
                    chk(nm, "ready32_busy", 32'(busy32), 32'd0);
                end else if (ready32) busy32++;
            end
            if (!got8) begin
                if (vout8) begin
                    got8 = 1;
                    chk(nm, "lat8", 32'(n), 32'(lat(o, 8)));
                    chk(nm, "data8", 32'(data8), 32'(e8));
                    chk(nm, "zero8", 32'(zero8), 32'(e8 == 8'd0));
                    chk(nm, "ready8_busy", 32'(busy8), 32'd0);
                end else if (ready8) busy8++;
            end
            if (!got32 || !got8) begin
                tick();
                n++;
            end
        end
        if (!got32) begin
            n_checks++; n_fail++;
            $display("FAIL %s.timeout32: valid_o got 0 within 64 edges, expected 1", nm);
        end
        if (!got8) begin
            n_checks++; n_fail++;
            $display("FAIL %s.timeout8: valid_o got 0 within 64 edges, expected 1", nm);
        end
    endtask

    task automatic add(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e32, input logic [7:0] e8);
        vec_t v;
        v = '{op: o, a: a, b: b, e32: e32, e8: e8};
        vt.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt;

        add(OP_ADD, 32'd5,          32'd7,          32'd12,         8'd12);
        add(OP_SUB, 32'd7,          32'd7,          32'd0,          8'd0);
        add(OP_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          8'd1);
        add(OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          8'd0);
        add(OP_MUL, 32'h0001_0000,  32'h0001_0001,  32'h0001_0000,  8'h00);
        add(3'b101, 32'h0000_1234,  32'h0000_5678,  32'h0000_1234,  8'h34);
        add(OP_AND, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  8'h00);
        add(OP_OR,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  8'hFF);
        add(OP_MUL, 32'h0000_00FF,  32'h0000_00FF,  32'h0000_FE01,  8'h01);
        add(OP_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,          8'd0);
        add(OP_SUB, 32'd3,          32'd5,          32'hFFFF_FFFE,  8'hFE);
        add(OP_SLT, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          8'd0);
`ifdef ALU_SEQ_DIV_EN
        add(OP_DIV, 32'd100,        32'd7,          32'd14,         8'd14);
        add(OP_DIV, 32'd100,        32'd0,          32'hFFFF_FFFF,  8'hFF);
        add(OP_DIV, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  8'h0F);
`else
        add(OP_DIV, 32'd100,        32'd7,          32'd100,        8'd100);
        add(OP_DIV, 32'd100,        32'd0,          32'd100,        8'd100);
        add(OP_DIV, 32'hFFFF_FFFF,  32'h10,         32'hFFFF_FFFF,  8'hFF);
`endif

        // Reset with a request pending: nothing may be accepted.
        rst_i = 1'b0; valid_i = 1'b1; op = OP_ADD; data1 = 32'd1; data2 = 32'd1;
        repeat (3) tick();
        chk("reset", "data32", data32, 32'd0);
        chk("reset", "zero32", 32'(zero32), 32'd1);
        chk("reset", "valid32", 32'(vout32), 32'd0);
        chk("reset", "data8", 32'(data8), 32'd0);
        chk("reset", "valid8", 32'(vout8), 32'd0);
        valid_i = 1'b0; rst_i = 1'b1;
        tick();
        chk("reset", "ready32", 32'(ready32), 32'd1);
        chk("reset", "ready8", 32'(ready8), 32'd1);

        for (int i = 0; i < vt.size(); i++)
            do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].e32, vt[i].e8, $sformatf("vec%0d", i));

        // valid_i held through a MUL is accepted only once ready returns.
        op = OP_MUL; data1 = 32'd3; data2 = 32'd5; valid_i = 1'b1;
        tick();
        op = OP_ADD; data1 = 32'd3; data2 = 32'd4;
        n = 1;
        while (!vout32 && n < 64) begin
            tick();
            n++;
        end
        chk("hold", "mul_lat", 32'(n), 32'd32);
        chk("hold", "mul_data", data32, 32'd15);
        chk("hold", "ready_at_valid", 32'(ready32), 32'd1);
        tick();
        valid_i = 1'b0;
        chk("hold", "add_valid", 32'(vout32), 32'd1);
        chk("hold", "add_data", data32, 32'd7);
        tick();
        chk("hold", "no_dup", 32'(vout32), 32'd0);

        // Reset during iteration 10 of a MUL aborts it silently.
        op = OP_MUL; data1 = 32'h0001_0000; data2 = 32'h0001_0001; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        cnt = 0;
        for (int k = 1; k < 10; k++) begin
            if (vout32) cnt++;
            tick();
        end
        rst_i = 1'b0;
        tick();
        chk("abort", "data32", data32, 32'd0);
        chk("abort", "zero32", 32'(zero32), 32'd1);
        chk("abort", "valid32", 32'(vout32), 32'd0);
        chk("abort", "zero8", 32'(zero8), 32'd1);
        rst_i = 1'b1;
        tick();
        chk("abort", "ready32", 32'(ready32), 32'd1);
        for (int k = 0; k < 40; k++) begin
            if (vout32) cnt++;
            tick();
        end
        chk("abort", "stray_valid", 32'(cnt), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 5) == 0) a = b;
            do_op(o, a, b, model(o, a, b, 32), 8'(model(o, a, b, 8)), $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
